// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: phase encodings, opcode patterns and defaults shared by the CPU sequencer.
package cpu_ctrl_pkg;
  localparam logic [3:0] PH_IDLE = 4'b0000;
  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;
  localparam int MLT_WAIT_DEF = 1;
  localparam logic [15:0] OP_MASK = 16'hF000;
  localparam logic [15:0] P_ADD  = 16'h1000;
  localparam logic [15:0] P_LI   = 16'h2000;
  localparam logic [15:0] P_B    = 16'h3000;
  localparam logic [15:0] P_BNZ  = 16'h4000;
  localparam logic [15:0] P_SGT  = 16'h5000;
  localparam logic [15:0] P_MLT  = 16'h6000;
  localparam logic [15:0] P_HALT = 16'hF000;
  typedef enum logic [3:0] {
    S_IDLE = PH_IDLE,
    S_PH0  = PH0,
    S_PH1  = PH1,
    S_PH2  = PH2,
    S_PH3  = PH3
  } state_t;
  function automatic logic op_is(input logic [15:0] ir, input logic [15:0] pat);
    return (ir & OP_MASK) == pat;
  endfunction
endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: instruction-memory request/acknowledge bus.
interface cpu_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: classifies the instruction register into one-hot control classes.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic        wr,
  output logic        br,
  output logic        mlt,
  output logic        halt,
  output logic        ill
);
  assign wr   = op_is(ir, P_ADD) | op_is(ir, P_LI) | op_is(ir, P_SGT);
  assign br   = op_is(ir, P_B) | op_is(ir, P_BNZ);
  assign mlt  = op_is(ir, P_MLT);
  assign halt = op_is(ir, P_HALT);
  assign ill  = !(wr | br | mlt | halt);
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: fetch/decode/execute/writeback phase sequencer owning pc and ir.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MLT_WAIT = MLT_WAIT_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run,
  cpu_ctrl_if.master  imem,
  input  logic [15:0] q,
  output logic [3:0]  ph,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        rf_we,
  output logic        halted,
  output logic        illegal
);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic wr, br, mlt, halt, ill;
  ctrl_decode u_dec (.ir(ir), .wr(wr), .br(br), .mlt(mlt), .halt(halt), .ill(ill));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pc      <= RESET_PC;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_PH0 && imem.imem_ack) begin
        ir <= imem.imem_data;
        pc <= pc + 16'd1;
      end
      if (state == S_PH3) begin
        if (br) pc <= q;
        if (halt) halted <= 1'b1;
        if (ill) illegal <= 1'b1;
      end
    end
  end
  // the stall count is loaded in PH1 so PH2 lasts exactly cnt+1 cycles
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: state_n = (run && !halted) ? S_PH0 : S_IDLE;
      S_PH0:  state_n = imem.imem_ack ? S_PH1 : S_PH0;
      S_PH1: begin
        state_n = S_PH2;
        cnt_n   = mlt ? 4'(MLT_WAIT) : 4'd0;
      end
      S_PH2: begin
        state_n = (cnt == 4'd0) ? S_PH3 : S_PH2;
        cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end
      S_PH3:  state_n = (!halt && run) ? S_PH0 : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  assign ph             = state;
  assign rf_we          = (state == S_PH3) && (wr || mlt);
  assign imem.imem_req  = (state == S_PH0);
  assign imem.imem_addr = pc;
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed scenarios against a cycle model of the phase sequencer.
module tb_cpu_ctrl;
  import cpu_ctrl_pkg::*;
  localparam logic [15:0] RPC = 16'h0000;
  localparam int W = 3;
  logic CLK = 1'b0, RST = 1'b1, run = 1'b0, stray = 1'b0;
  logic [15:0] q = '0;
  logic [3:0] ph;
  logic [15:0] pc, ir;
  logic rf_we, halted, illegal;
  int checks = 0, failures = 0;
  int ack_delay = 0, ffff_dly = 0, wcnt = 0;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] qtab [logic [15:0]];
  cpu_ctrl_if bus ();
  cpu_ctrl #(.RESET_PC(RPC), .MLT_WAIT(W)) dut (
    .CLK(CLK), .RST(RST), .run(run), .imem(bus), .q(q), .ph(ph), .pc(pc), .ir(ir),
    .rf_we(rf_we), .halted(halted), .illegal(illegal)
  );
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h7000;
  endfunction
  function automatic logic [15:0] rd_q(input logic [15:0] a);
    return qtab.exists(a) ? qtab[a] : 16'h0000;
  endfunction
  // 0 writes a register, 1 branches, 2 multiplies, 3 halts, 4 is undecoded
  function automatic int klass(input logic [15:0] w);
    case (w[15:12])
      4'h1, 4'h2, 4'h5: return 0;
      4'h3, 4'h4: return 1;
      4'h6: return 2;
      4'hF: return 3;
      default: return 4;
    endcase
  endfunction

  // memory and ALU stand-ins
  always @(negedge CLK) begin
    q = rd_q(pc);
    if (bus.imem_req) begin
      if (wcnt >= ((bus.imem_addr == 16'hFFFF) ? ffff_dly : ack_delay)) begin
        bus.imem_ack = 1'b1;
        bus.imem_data = rd_mem(bus.imem_addr);
        wcnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.imem_ack = stray;
      bus.imem_data = 16'hDEAD;
      wcnt = 0;
    end
  end

  logic [3:0] m_ph;
  logic [15:0] m_pc, m_ir;
  logic m_h, m_ill, m_valid = 1'b0;
  logic [3:0] sched [$];
  always @(posedge CLK) begin
    if (RST) begin
      m_valid = 1'b1; m_ph = PH_IDLE; m_pc = RPC; m_ir = '0; m_h = 1'b0; m_ill = 1'b0;
      sched.delete();
    end else if (m_valid) begin
      if (m_ph == PH_IDLE) m_ph = (run && !m_h) ? PH0 : PH_IDLE;
      else if (m_ph == PH0) begin
        if (bus.imem_ack) begin
          m_ir = bus.imem_data;
          m_pc = m_pc + 16'd1;
          sched.push_back(PH1);
          repeat (klass(m_ir) == 2 ? W + 1 : 1) sched.push_back(PH2);
          sched.push_back(PH3);
          m_ph = sched.pop_front();
        end
      end else if (m_ph == PH3) begin
        case (klass(m_ir))
          1: m_pc = q;
          3: m_h = 1'b1;
          4: m_ill = 1'b1;
          default: ;
        endcase
        m_ph = (klass(m_ir) != 3 && run) ? PH0 : PH_IDLE;
      end else m_ph = sched.pop_front();
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("ph", 32'(ph), 32'(m_ph));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("rf_we", 32'(rf_we), 32'(m_ph == PH3 && (klass(m_ir) == 0 || klass(m_ir) == 2)));
      chk("imem_req", 32'(bus.imem_req), 32'(m_ph == PH0));
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_h));
      chk("illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic do_reset();
    RST = 1'b1; run = 1'b0; stray = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_ph(input logic [3:0] target, input string nm);
    int n = 0;
    while (ph !== target && n < 200) begin @(negedge CLK); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s: timeout waiting for ph=%0h, got %0h", nm, target, ph);
    end
  endtask

  task automatic measure(input string nm, output int n, output int nreq, output int nwe, output logic [15:0] tr);
    n = 0; nreq = 0; nwe = 0; tr = '0;
    wait_ph(PH0, nm);
    for (int i = 0; i < 100; i++) begin
      n++;
      nreq += int'(bus.imem_req);
      nwe += int'(rf_we);
      if (n <= 4) tr = {tr[11:0], ph};
      if (ph == PH3) break;
      @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  initial begin
    int n, nr, nw;
    logic [15:0] tr;
    bus.imem_ack = 1'b0; bus.imem_data = '0;
    mem[16'h0000] = 16'h2005; mem[16'h0001] = 16'hF000;
    do_reset();
    chk("rst_ph", 32'(ph), 32'h0); chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_ir", 32'(ir), 32'h0); chk("rst_halted", 32'(halted), 32'h0);
    run = 1'b1;
    measure("li", n, nr, nw, tr);
    chk("li_latency", n, 4); chk("li_trace", 32'(tr), 32'h1248);
    chk("li_we", nw, 1); chk("li_req", nr, 1);
    chk("li_pc", 32'(pc), 32'h0001); chk("li_ir", 32'(ir), 32'h2005);
    wait_ph(PH3, "halt");
    @(negedge CLK);
    chk("halt_ph", 32'(ph), 32'h0); chk("halt_flag", 32'(halted), 32'h1);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      run = (i % 3) != 1;
      @(negedge CLK);
      nr += int'(bus.imem_req);
    end
    chk("halt_noreq", nr, 0); chk("halt_sticky", 32'(halted), 32'h1);
    do_reset();
    chk("halt_cleared", 32'(halted), 32'h0);

    mem[16'h0000] = 16'h1123; ack_delay = 3;
    do_reset(); run = 1'b1;
    measure("wait", n, nr, nw, tr);
    chk("wait_latency", n, 7); chk("wait_req", nr, 4); chk("wait_we", nw, 1);
    wait_ph(PH_IDLE, "wait_idle");
    ack_delay = 0;

    mem[16'h0000] = 16'h3000; qtab[16'h0001] = 16'h0010;
    mem[16'h0010] = 16'h4008; qtab[16'h0011] = 16'h0008; mem[16'h0008] = 16'hF000;
    do_reset(); run = 1'b1;
    measure("b", n, nr, nw, tr);
    chk("b_target", 32'(bus.imem_addr), 32'h0010); chk("b_we", nw, 0);
    measure("bnz_t", n, nr, nw, tr);
    chk("bnz_taken", 32'(bus.imem_addr), 32'h0008);
    wait_ph(PH_IDLE, "bnz_idle");
    qtab[16'h0011] = 16'h0011; mem[16'h0011] = 16'hF000;
    do_reset(); run = 1'b1;
    measure("b2", n, nr, nw, tr);
    measure("bnz_nt", n, nr, nw, tr);
    chk("bnz_fall", 32'(bus.imem_addr), 32'h0011);
    wait_ph(PH_IDLE, "bnz2_idle");

    mem[16'h0000] = 16'h6123; mem[16'h0001] = 16'h1456;
    mem[16'h0002] = 16'h7000; mem[16'h0003] = 16'hF000;
    do_reset(); run = 1'b1; stray = 1'b1;
    measure("mlt", n, nr, nw, tr);
    chk("mlt_latency", n, 7); chk("mlt_we", nw, 1);
    measure("add", n, nr, nw, tr);
    chk("add_latency", n, 4); chk("add_we", nw, 1);
    measure("ill", n, nr, nw, tr);
    chk("ill_latency", n, 4); chk("ill_we", nw, 0); chk("ill_flag", 32'(illegal), 32'h1);
    wait_ph(PH_IDLE, "mlt_idle");
    stray = 1'b0;

    mem[16'h0000] = 16'h3000; qtab[16'h0001] = 16'hFFFF; mem[16'hFFFF] = 16'h6777;
    do_reset(); run = 1'b1;
    measure("b_ffff", n, nr, nw, tr);
    chk("ffff_addr", 32'(bus.imem_addr), 32'hFFFF);
    wait_ph(PH1, "wrap_ph1");
    chk("wrap_pc", 32'(pc), 32'h0000); chk("wrap_ir", 32'(ir), 32'h6777);
    wait_ph(PH2, "wrap_ph2");
    @(negedge CLK);
    RST = 1'b1; run = 1'b0;
    @(negedge CLK);
    chk("stall_rst_ph", 32'(ph), 32'h0); chk("stall_rst_pc", 32'(pc), 32'h0000);
    chk("stall_rst_ir", 32'(ir), 32'h0);
    RST = 1'b0;

    ffff_dly = 20;
    do_reset(); run = 1'b1;
    measure("b_ffff2", n, nr, nw, tr);
    repeat (3) @(negedge CLK);
    chk("pend_addr", 32'(bus.imem_addr), 32'hFFFF); chk("pend_req", 32'(bus.imem_req), 32'h1);
    RST = 1'b1; run = 1'b0;
    @(negedge CLK);
    chk("fetch_rst_ph", 32'(ph), 32'h0); chk("fetch_rst_pc", 32'(pc), 32'h0000);
    chk("fetch_rst_req", 32'(bus.imem_req), 32'h0);
    RST = 1'b0;
    mem[16'h0000] = 16'h6001; mem[16'h0001] = 16'hF000;
    @(negedge CLK); run = 1'b1;
    measure("mlt_clean", n, nr, nw, tr);
    chk("mlt_clean_latency", n, 7);
    wait_ph(PH_IDLE, "final_idle");
    run = 1'b0;
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Phase sequencer for the multi-cycle CPU. Steps the ALU and register file through fetch, decode, execute and writeback, and owns `pc` and `ir`. Drives the instruction-memory request/acknowledge handshake. Supplies the `ph`, `pc` and `ir` buses that the ALU and register file decode.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, `pc` value after reset
- `MLT_WAIT`, 1, extra PH2 cycles held for MLT (range 0..15)

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  reset, synchronous, active-high
- `run`  in  1  level enable; sampled in IDLE and at the end of PH3
- `imem_req`  out  1  fetch request, high throughout PH0
- `imem_addr`  out  16  fetch address, equal to `pc`
- `imem_ack`  in  1  fetch complete; `imem_data` valid in the same cycle
- `imem_data`  in  16  fetched instruction word
- `q`  in  16  ALU result, valid during PH3
- `ph`  out  4  current phase, one-hot; 4'b0000 means IDLE
- `pc`  out  16  program counter
- `ir`  out  16  instruction register
- `rf_we`  out  1  register-file write strobe
- `halted`  out  1  sticky, set by HALT
- `illegal`  out  1  sticky, set by an undecoded `ir`

## Operation
- States are IDLE, PH0 (fetch), PH1 (decode/register read), PH2 (execute), PH3 (writeback). `ph` is the registered state.
- IDLE: moves to PH0 when `run`=1 and `halted`=0. Otherwise stays in IDLE.
- PH0:
  - `imem_req`=1.
  - On `imem_ack`=1: `ir`<=`imem_data`, `pc`<=`pc`+1 (wraps 16'hFFFF→16'h0000), then go to PH1.
  - Without ack: stay in PH0 and hold `imem_addr`. No timeout.
- PH1: one cycle, unconditional move to PH2.
- PH2:
  - Non-MLT: one cycle.
  - MLT: 1+`MLT_WAIT` cycles, counted by a 4-bit down-counter. The ALU recomputes `q` every PH2 cycle, so the last edge captures the settled product.
- PH3, by instruction class:
  - ADD, LI, SGT, MLT: `rf_we`=1.
  - B, BNZ: `pc`<=`q`. `q` is already `pc`+imm8 or the unchanged `pc`, so BNZ not-taken falls through. `pc` seen by the ALU is the post-increment value.
  - HALT: `halted`<=1, next state IDLE.
  - No pattern match: `illegal`<=1, executed as a NOP.
  - Otherwise the next state is PH0 if `run`=1, else IDLE.
- `run` falling mid-instruction has no effect until the end of PH3.
- `imem_ack` outside PH0 is ignored.
- `RST`=1 dominates every state, including mid-fetch and a PH2 stall. The cycle after `RST`, every output holds its reset value:
  - `ph`=4'b0000, `pc`=`RESET_PC`, `ir`=16'h0000
  - `rf_we`=0, `imem_req`=0
  - `halted`=0, `illegal`=0
  - stall counter cleared
- `halted` clears only on `RST`.

## Timing
- `imem_req`, `imem_addr` and `rf_we` decode combinationally from registered state only. No input-to-output combinational path.
- Instruction latency with ack in the first PH0 cycle: 4 cycles (PH0,PH1,PH2,PH3). MLT: 4+`MLT_WAIT`. Each PH0 wait cycle adds one.
- `rf_we` is high for exactly one cycle, during PH3. The register file writes `q` on the edge that ends PH3.
- The `pc` change from a branch is visible in the cycle after PH3, which is the next PH0 address.
- Back-to-back instructions with `run` held high have no bubble: PH3 is followed directly by PH0.

## Structure
- `defines.h` gains:
  - `PH0`..`PH3` one-hot constants and `PH_IDLE`=4'b0000
  - a `HALT` casex pattern
  - `MLT_WAIT`'s default
  - These sit alongside the existing ADD/LI/B/BNZ/SGT/MLT patterns.
- One combinational sub-module, `ctrl_decode`:
  - input: `ir`
  - outputs one-hot class flags: `wr`, `br`, `mlt`, `halt`, `ill`
  - uses the `defines.h` casex patterns
  - The FSM, counter, `pc` and `ir` stay in `cpu_ctrl`.

## Test plan
- Reset/run: `RST` pulse then `run`=1; memory acks immediately with LI → `ph` walks 0001,0010,0100,1000. `rf_we` is high only in PH3. `pc` reads 1 from PH1 on.
- Fetch wait: ack delayed 3 cycles → `imem_req` held 4 cycles with constant `imem_addr`. The instruction takes 7 cycles total.
- BNZ at `pc`=16'h0010: `q`=16'h0008 in PH3 → next `imem_addr`=16'h0008. `q`=16'h0011 → falls through to 16'h0011.
- MLT with `MLT_WAIT`=3 → PH2 lasts 4 cycles, `rf_we` pulses once, instruction takes 7 cycles. ADD that follows → 4 cycles.
- HALT, then `run` held high → returns to IDLE with `halted`=1 and no further `imem_req`. Only `RST` clears it.
- `RST` asserted mid-PH2 stall, with `pc`=16'hFFFF and ack pending → after reset, `pc`=`RESET_PC`, `ph`=0, `ir`=0. The wrap case from `pc`=16'hFFFF fetches and then reads `pc`=0.
